apu_multichannel: RTL

- Parametrised successor to the single-voice APU: NUM_CH independent one-shot tone channels, each with a selectable waveform and a decaying volume envelope.
- Channels are started by game-event strobes, such as collision pulses.
- Active channels are combined by priority select or by saturating mix, then emitted as a 1-bit PWM audio output.
- Sits between the collision/event logic and the audio pin.

---
 rtl/apu_multichannel_if.sv | 17 +
 rtl/apu_multichannel.sv | 117 +++++++++++
 2 files changed

// File: rtl/apu_multichannel_if.sv
// apu_multichannel_if: event strobes, per-channel tone config and audio outputs
interface apu_multichannel_if #(
   parameter int NUM_CH = 3,
   parameter int PERIOD_BITS = 16,
   parameter int DUR_BITS = 16
);
   logic [NUM_CH-1:0] trig;
   logic [NUM_CH*PERIOD_BITS-1:0] cfg_period;
   logic [NUM_CH*2-1:0] cfg_wave;
   logic [NUM_CH*DUR_BITS-1:0] cfg_dur;
   logic [NUM_CH-1:0] active;
   logic [NUM_CH-1:0] done;
   logic [7:0] level;
   logic sound;
   modport master (output trig, cfg_period, cfg_wave, cfg_dur, input active, done, level, sound);
   modport slave (input trig, cfg_period, cfg_wave, cfg_dur, output active, done, level, sound);
endinterface

// File: rtl/apu_multichannel.sv
// apu_multichannel: NUM_CH one-shot tone channels with decaying envelopes, mixed to 1-bit PWM
module apu_multichannel #(
   parameter int NUM_CH = 3,
   parameter int PERIOD_BITS = 16,
   parameter int DUR_BITS = 16,
   parameter int MIX_MODE = 0,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic clk,
   input logic reset_n,
   apu_multichannel_if.slave bus
);
   localparam int SUM_W = 8 + $clog2(NUM_CH);
   logic [PERIOD_BITS-1:0] per [NUM_CH];
   logic [PERIOD_BITS-1:0] phase [NUM_CH];
   logic [DUR_BITS-1:0] dur [NUM_CH];
   logic [DUR_BITS-1:0] dcnt [NUM_CH];
   logic [1:0] wave [NUM_CH];
   logic [3:0] vol [NUM_CH];
   logic [7:0] ramp [NUM_CH];
   logic [7:0] lfsr [NUM_CH];
   logic [7:0] amp [NUM_CH];
   logic [NUM_CH-1:0] play, sq, done_q;
   logic [7:0] level_q, level_next, pick, pwm_cnt;
   logic sound_q;
   logic [SUM_W-1:0] sum;

   assign bus.active = play;
   assign bus.done = done_q;
   assign bus.level = level_q;
   assign bus.sound = sound_q;

   // waveform sample scaled by the 4-bit envelope, full 12-bit product then top 8 bits
   function automatic logic [7:0] scale(input logic [1:0] w, input logic s, input logic [7:0] r,
                                        input logic [7:0] l, input logic [3:0] v);
      logic [7:0] x;
      logic [11:0] p;
      x = w == 2'd0 ? {8{s}} : w == 2'd1 ? r : w == 2'd2 ? l : 8'd0;
      p = x * v;
      return p[11:4];
   endfunction

   // per-channel sequencing: start/restart on trig, tone ticks and envelope decay while playing
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            per[c] <= '0;
            phase[c] <= '0;
            dur[c] <= '0;
            dcnt[c] <= '0;
            wave[c] <= '0;
            vol[c] <= '0;
            ramp[c] <= '0;
            lfsr[c] <= LFSR_SEED;
         end
         play <= '0;
         sq <= '0;
         done_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            done_q[c] <= 1'b0;
            if (bus.trig[c]) begin
               play[c] <= 1'b1;
               vol[c] <= 4'd15;
               per[c] <= bus.cfg_period[c*PERIOD_BITS +: PERIOD_BITS];
               phase[c] <= bus.cfg_period[c*PERIOD_BITS +: PERIOD_BITS];
               dur[c] <= bus.cfg_dur[c*DUR_BITS +: DUR_BITS];
               dcnt[c] <= bus.cfg_dur[c*DUR_BITS +: DUR_BITS];
               wave[c] <= bus.cfg_wave[c*2 +: 2];
               sq[c] <= 1'b0;
               ramp[c] <= 8'd0;
            end else if (play[c]) begin
               phase[c] <= phase[c] == '0 ? per[c] : phase[c] - 1'b1;
               if (phase[c] == '0) begin
                  sq[c] <= ~sq[c];
                  ramp[c] <= ramp[c] + 8'd1;
                  lfsr[c] <= {lfsr[c][6:0], ^(lfsr[c] & 8'hB8)};
               end
               if (dcnt[c] != '0)
                  dcnt[c] <= dcnt[c] - 1'b1;
               else if (vol[c] > 4'd1) begin
                  vol[c] <= vol[c] - 4'd1;
                  dcnt[c] <= dur[c];
               end else begin
                  play[c] <= 1'b0;
                  vol[c] <= 4'd0;
                  done_q[c] <= 1'b1;
               end
            end
         end
      end

   // channel amplitudes and the mix: lowest active index wins, or clamped sum of all
   always_comb begin
      sum = '0;
      pick = 8'd0;
      for (int c = 0; c < NUM_CH; c++)
         amp[c] = play[c] ? scale(wave[c], sq[c], ramp[c], lfsr[c], vol[c]) : 8'd0;
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (play[c]) pick = amp[c];
      for (int c = 0; c < NUM_CH; c++)
         sum = sum + SUM_W'(amp[c]);
      level_next = MIX_MODE == 1 ? (sum > SUM_W'(255) ? 8'hFF : sum[7:0]) : pick;
   end

   // registered level and PWM comparator against a free-running 8-bit counter
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         level_q <= 8'd0;
         sound_q <= 1'b0;
         pwm_cnt <= 8'd0;
      end else begin
         level_q <= level_next;
         sound_q <= pwm_cnt < level_q;
         pwm_cnt <= pwm_cnt + 8'd1;
      end
endmodule
